// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command constants and arbiter state encoding
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [3:0] {
        ST_INIT  = 4'b0001,
        ST_ARBIT = 4'b0010,
        ST_AREF  = 4'b0100,
        ST_XFER  = 4'b1000
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, first requester at or after ptr
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              valid
);

    localparam int IDX2_W = $clog2(2 * NUM_CH);

    logic [NUM_CH-1:0]   lo_mask;
    logic [2*NUM_CH-1:0] dbl;
    logic [IDX2_W-1:0]   idx2;

    // Upper copy holds all requests, lower copy only those at/after ptr, so the
    // lowest set bit of the doubled vector is the wrapped round-robin winner.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lo_mask[i] = (i < int'(ptr));
        end
        dbl  = {req, req & ~lo_mask};
        idx2 = '0;
        for (int i = 2 * NUM_CH - 1; i >= 0; i--) begin
            if (dbl[i]) idx2 = IDX2_W'(i);
        end
        idx = (idx2 >= IDX2_W'(NUM_CH)) ? PTR_W'(idx2 - IDX2_W'(NUM_CH)) : PTR_W'(idx2);
        grant = '0;
        if (|req) grant[idx] = 1'b1;
    end

    assign valid = |req;

endmodule

// File: rtl/sdram_arbiter_mc.sv
// rtl/sdram_arbiter_mc.sv - multi-channel SDRAM command arbiter with refresh priority and watchdog
module sdram_arbiter_mc
    import sdram_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int TMO_W  = 12,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic                     sclk,
    input  logic                     s_rst_n,
    input  logic                     init_done,
    input  logic [3:0]               init_cmd,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic                     ref_req,
    input  logic                     ref_end,
    input  logic [3:0]               ref_cmd,
    input  logic [ADDR_W-1:0]        ref_addr,
    output logic                     ref_en,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_is_wr,
    input  logic [NUM_CH-1:0]        ch_end,
    input  logic [4*NUM_CH-1:0]      ch_cmd,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [BA_W*NUM_CH-1:0]   ch_bank,
    input  logic [DQ_W*NUM_CH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]        ch_en,
    output logic                     ref_pend,
    output logic [3:0]               sdram_cmd,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [BA_W-1:0]          sdram_bank,
    output logic [DQ_W-1:0]          sdram_dq_out,
    output logic                     sdram_dq_oe,
    output logic [PTR_W-1:0]         cur_ch,
    output logic                     tmo_err
);

    state_t             state, state_nxt;
    logic [NUM_CH-1:0]  grant;
    logic [PTR_W-1:0]   cur_ch_q;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [TMO_W-1:0]   wdog;
    logic [NUM_CH-1:0]  arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               end_hit;
    logic               tmo_hit;
    logic               start_xfer;
    logic               leave_xfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // A normal end in the expiry cycle takes precedence over the timeout.
    assign end_hit    = |(ch_end & grant);
    assign tmo_hit    = (state == ST_XFER) && (wdog == '1) && !end_hit;
    assign start_xfer = (state == ST_ARBIT) && (state_nxt == ST_XFER);
    assign leave_xfer = (state == ST_XFER) && (state_nxt != ST_XFER);
    assign next_ptr   = (cur_ch_q == PTR_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (init_done) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                if (!init_done)     state_nxt = ST_INIT;
                else if (ref_req)   state_nxt = ST_AREF;
                else if (arb_valid) state_nxt = ST_XFER;
            end
            ST_AREF:  if (ref_end) state_nxt = ST_ARBIT;
            ST_XFER:  if (end_hit || tmo_hit) state_nxt = ST_ARBIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            grant    <= '0;
            cur_ch_q <= '0;
            rr_ptr   <= '0;
            wdog     <= '0;
            ref_en   <= 1'b0;
            ch_en    <= '0;
            tmo_err  <= 1'b0;
        end else begin
            ref_en  <= (state == ST_ARBIT) && (state_nxt == ST_AREF);
            ch_en   <= start_xfer ? arb_grant : '0;
            tmo_err <= tmo_hit;
            wdog    <= (state == ST_XFER && state_nxt == ST_XFER) ? wdog + 1'b1 : '0;
            if (start_xfer) begin
                grant    <= arb_grant;
                cur_ch_q <= arb_idx;
            end
            if (leave_xfer) rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_addr  = '0;
        sdram_bank  = '0;
        sdram_dq_oe = 1'b0;
        ref_pend    = 1'b0;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_XFER: begin
                sdram_cmd   = ch_cmd[int'(cur_ch_q) * 4 +: 4];
                sdram_addr  = ch_addr[int'(cur_ch_q) * ADDR_W +: ADDR_W];
                sdram_bank  = ch_bank[int'(cur_ch_q) * BA_W +: BA_W];
                sdram_dq_oe = ch_is_wr[cur_ch_q];
                ref_pend    = ref_req;
            end
            default: ;
        endcase
    end

    assign sdram_dq_out = ch_wdata[int'(cur_ch_q) * DQ_W +: DQ_W];
    assign cur_ch       = cur_ch_q;

endmodule

// File: tb/tb_sdram_arbiter_mc.sv
// tb/tb_sdram_arbiter_mc.sv - self-checking bench for sdram_arbiter_mc
module tb_sdram_arbiter_mc;

    localparam int N = 4, DQ_W = 16, ADDR_W = 13, BA_W = 2, TMO_W = 12;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic              init_done;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              ref_req, ref_end;
    logic [3:0]        ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_en;
    logic [N-1:0]      ch_req, ch_is_wr, ch_end, ch_en;
    logic [4*N-1:0]    ch_cmd;
    logic [ADDR_W*N-1:0] ch_addr;
    logic [BA_W*N-1:0] ch_bank;
    logic [DQ_W*N-1:0] ch_wdata;
    logic              ref_pend;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_bank;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;
    logic [1:0]        cur_ch;
    logic              tmo_err;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    sdram_arbiter_mc #(.NUM_CH(N), .DQ_W(DQ_W), .ADDR_W(ADDR_W), .BA_W(BA_W), .TMO_W(TMO_W)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .init_done(init_done), .init_cmd(init_cmd),
        .init_addr(init_addr), .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd),
        .ref_addr(ref_addr), .ref_en(ref_en), .ch_req(ch_req), .ch_is_wr(ch_is_wr),
        .ch_end(ch_end), .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_bank(ch_bank),
        .ch_wdata(ch_wdata), .ch_en(ch_en), .ref_pend(ref_pend), .sdram_cmd(sdram_cmd),
        .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe), .cur_ch(cur_ch), .tmo_err(tmo_err)
    );

    always #5 sclk = ~sclk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_data();
        init_cmd  = 4'($urandom);
        init_addr = ADDR_W'($urandom);
        ref_cmd   = 4'($urandom);
        ref_addr  = ADDR_W'($urandom);
        ch_cmd    = 16'($urandom);
        ch_addr   = 52'({$urandom(), $urandom()});
        ch_bank   = 8'($urandom);
        ch_wdata  = 64'({$urandom(), $urandom()});
    endtask

    task automatic wait_grant(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sclk);
            if (|ch_en) found = 1'b1;
        end
    endtask

    task automatic end_xfer(input int w);
        ch_end[w] = 1'b1;
        @(negedge sclk);
        ch_end = '0;
        model_ptr = (w + 1) % N;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; init_done = 1'b0; ref_req = 1'b0; ref_end = 1'b0;
        ch_req = '0; ch_is_wr = '1; ch_end = '0;
        rand_data();
        repeat (2) @(negedge sclk);
        checks++; if (sdram_cmd !== init_cmd) begin errors++; $display("FAIL reset_cmd: got %h expected %h", sdram_cmd, init_cmd); end
        checks++; if (sdram_addr !== init_addr) begin errors++; $display("FAIL reset_addr: got %h expected %h", sdram_addr, init_addr); end
        checks++; if ({ch_en, ref_en, tmo_err, ref_pend, sdram_dq_oe} !== 8'h00) begin errors++; $display("FAIL reset_pulses: got %b expected 0", {ch_en, ref_en, tmo_err, ref_pend, sdram_dq_oe}); end
        checks++; if (cur_ch !== 2'd0 || sdram_bank !== 2'd0) begin errors++; $display("FAIL reset_idx: got cur_ch=%0d bank=%0d expected 0/0", cur_ch, sdram_bank); end
        s_rst_n = 1'b1;
    endtask

    task automatic test_init();
        repeat (200) @(negedge sclk);
        checks++; if (sdram_cmd !== init_cmd) begin errors++; $display("FAIL init_cmd: got %h expected %h", sdram_cmd, init_cmd); end
        init_done = 1'b1;
        @(negedge sclk);
        checks++; if (sdram_cmd !== 4'b0111 || sdram_addr !== '0) begin errors++; $display("FAIL arbit_nop: got %h/%h expected 7/0", sdram_cmd, sdram_addr); end
    endtask

    task automatic test_ref_priority();
        bit found;
        ref_req = 1'b1; ch_req = 4'b0011;
        @(negedge sclk);
        checks++; if (ref_en !== 1'b1 || ch_en !== 4'b0000) begin errors++; $display("FAIL ref_grant: got ref_en=%b ch_en=%b expected 1/0000", ref_en, ch_en); end
        checks++; if (sdram_cmd !== ref_cmd || sdram_addr !== ref_addr) begin errors++; $display("FAIL ref_mux: got %h/%h expected %h/%h", sdram_cmd, sdram_addr, ref_cmd, ref_addr); end
        ref_req = 1'b0;
        @(negedge sclk);
        checks++; if (ref_en !== 1'b0 || ch_en !== 4'b0000) begin errors++; $display("FAIL ref_pulse_len: got ref_en=%b ch_en=%b expected 0/0000", ref_en, ch_en); end
        repeat (3) @(negedge sclk);
        ref_end = 1'b1;
        @(negedge sclk);
        ref_end = 1'b0;
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'b0001 || cur_ch !== 2'd0) begin errors++; $display("FAIL post_ref_grant: got ch_en=%b cur_ch=%0d expected 0001/0", ch_en, cur_ch); end
        end_xfer(0);
        ch_req = '0;
    endtask

    task automatic test_round_robin();
        bit found;
        logic [N-1:0] req;
        logic [4*N-1:0] cmdv;
        logic [ADDR_W*N-1:0] addrv;
        logic [BA_W*N-1:0] bankv;
        logic [DQ_W*N-1:0] wdv;
        int exp;
        ch_is_wr = 4'b0101;
        for (int t = 0; t < 17; t++) begin
            req = (t < 5) ? 4'b1111 : 4'($urandom_range(1, 15));
            if (t >= 5) ch_is_wr = 4'($urandom);
            rand_data();
            cmdv = ch_cmd; addrv = ch_addr; bankv = ch_bank; wdv = ch_wdata;
            ch_req = req;
            exp = pick(req, model_ptr);
            wait_grant(found);
            checks++; if (!found || ch_en !== 4'(1 << exp) || cur_ch !== 2'(exp)) begin errors++; $display("FAIL rr_grant[%0d]: got ch_en=%b cur_ch=%0d expected ch%0d", t, ch_en, cur_ch, exp); end
            checks++; if (sdram_cmd !== cmdv[exp*4 +: 4] || sdram_addr !== addrv[exp*ADDR_W +: ADDR_W] || sdram_bank !== bankv[exp*BA_W +: BA_W]) begin errors++; $display("FAIL rr_mux[%0d]: got %h/%h/%h expected %h/%h/%h", t, sdram_cmd, sdram_addr, sdram_bank, cmdv[exp*4 +: 4], addrv[exp*ADDR_W +: ADDR_W], bankv[exp*BA_W +: BA_W]); end
            checks++; if (sdram_dq_out !== wdv[exp*DQ_W +: DQ_W] || sdram_dq_oe !== ch_is_wr[exp]) begin errors++; $display("FAIL rr_dq[%0d]: got %h oe=%b expected %h oe=%b", t, sdram_dq_out, sdram_dq_oe, wdv[exp*DQ_W +: DQ_W], ch_is_wr[exp]); end
            repeat (8) @(negedge sclk);
            checks++; if (ch_en !== 4'b0000 || sdram_cmd !== cmdv[exp*4 +: 4]) begin errors++; $display("FAIL rr_hold[%0d]: got ch_en=%b cmd=%h expected 0000/%h", t, ch_en, sdram_cmd, cmdv[exp*4 +: 4]); end
            end_xfer(exp);
        end
        ch_req = '0;
    endtask

    task automatic test_ignore_other();
        bit found;
        logic [4*N-1:0] cmdv;
        int exp;
        rand_data();
        cmdv = ch_cmd;
        ch_req = 4'b0100;
        exp = pick(ch_req, model_ptr);
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'b0100) begin errors++; $display("FAIL ign_grant: got %b expected 0100", ch_en); end
        ch_end = 4'b0010; ch_req = 4'b1111;
        @(negedge sclk);
        ch_end = '0;
        @(negedge sclk);
        checks++; if (sdram_cmd !== cmdv[exp*4 +: 4] || cur_ch !== 2'd2) begin errors++; $display("FAIL ign_end: got cmd=%h cur_ch=%0d expected %h/2", sdram_cmd, cur_ch, cmdv[exp*4 +: 4]); end
        ref_req = 1'b1;
        #1;
        checks++; if (ref_pend !== 1'b1) begin errors++; $display("FAIL ref_pend_on: got %b expected 1", ref_pend); end
        @(negedge sclk);
        checks++; if (ref_en !== 1'b0 || sdram_cmd !== cmdv[exp*4 +: 4]) begin errors++; $display("FAIL ref_in_xfer: got ref_en=%b cmd=%h expected 0/%h", ref_en, sdram_cmd, cmdv[exp*4 +: 4]); end
        ref_req = 1'b0;
        #1;
        checks++; if (ref_pend !== 1'b0) begin errors++; $display("FAIL ref_pend_off: got %b expected 0", ref_pend); end
        ch_req = '0;
        end_xfer(exp);
    endtask

    task automatic test_watchdog();
        bit found;
        int at_n;
        ch_req = 4'b0010;
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'b0010) begin errors++; $display("FAIL wd_grant: got %b expected 0010", ch_en); end
        ch_req = 4'b0110;
        at_n = -1;
        for (int n = 1; n <= 4200 && at_n < 0; n++) begin
            @(negedge sclk);
            if (tmo_err === 1'b1) at_n = n;
        end
        checks++; if (at_n < 4094 || at_n > 4098) begin errors++; $display("FAIL wd_expiry: got cycle %0d expected about 4095", at_n); end
        checks++; if (sdram_cmd !== 4'b0111) begin errors++; $display("FAIL wd_arbit: got cmd=%h expected 7", sdram_cmd); end
        model_ptr = 2;
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'(1 << pick(4'b0110, model_ptr)) || tmo_err !== 1'b0) begin errors++; $display("FAIL wd_next: got ch_en=%b tmo_err=%b expected 0100/0", ch_en, tmo_err); end
        ch_req = '0;
        end_xfer(2);
    endtask

    task automatic test_async_reset();
        bit found;
        ch_req = 4'b1000; ch_is_wr = 4'b1000;
        rand_data();
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'(1 << pick(4'b1000, model_ptr))) begin errors++; $display("FAIL ar_grant: got %b expected 1000", ch_en); end
        ch_req = 4'b1111; ref_req = 1'b1;
        repeat (3) @(negedge sclk);
        #2;
        s_rst_n = 1'b0;
        #1;
        checks++; if ({ch_en, ref_en, tmo_err, ref_pend, sdram_dq_oe} !== 8'h00 || cur_ch !== 2'd0) begin errors++; $display("FAIL ar_outputs: got %b cur_ch=%0d expected 0/0", {ch_en, ref_en, tmo_err, ref_pend, sdram_dq_oe}, cur_ch); end
        checks++; if (sdram_cmd !== init_cmd || sdram_bank !== 2'd0) begin errors++; $display("FAIL ar_mux: got %h/%h expected %h/0", sdram_cmd, sdram_bank, init_cmd); end
        ref_req = 1'b0; init_done = 1'b0;
        @(negedge sclk);
        s_rst_n = 1'b1;
        model_ptr = 0;
        init_done = 1'b1;
        wait_grant(found);
        checks++; if (!found || ch_en !== 4'(1 << pick(4'b1111, model_ptr)) || cur_ch !== 2'd0) begin errors++; $display("FAIL ar_regrant: got ch_en=%b cur_ch=%0d expected 0001/0", ch_en, cur_ch); end
        end_xfer(0);
        ch_req = '0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_ref_priority();
        test_round_robin();
        test_ignore_other();
        test_watchdog();
        test_async_reset();
        repeat (2) @(negedge sclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
